// File: rtl/butterfly_hs.sv
// Pipelined radix-2 complex butterfly (per-beat DIF/DIT) with valid/ready handshake and sticky overflow.
// Optional feature: define BUTTERFLY_HS_SAT_EN to saturate overflowing outputs instead of wrapping.
`timescale 1ns/1ps
module butterfly_hs #(
    parameter int unsigned IWIDTH = 16,
    parameter int unsigned CWIDTH = 20,
    parameter int unsigned OWIDTH = 17,
    parameter int unsigned SHIFT  = 0
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_clk_enable,
    input  logic [2*IWIDTH-1:0] i_left,
    input  logic [2*IWIDTH-1:0] i_right,
    input  logic [2*CWIDTH-1:0] i_coef,
    input  logic                i_dit,
    input  logic                i_aux,
    input  logic                i_valid,
    output logic                o_ready,
    output logic [2*OWIDTH-1:0] o_left,
    output logic [2*OWIDTH-1:0] o_right,
    output logic                o_aux,
    output logic                o_valid,
    input  logic                i_ready,
    input  logic                i_ovf_clr,
    output logic                o_ovf
);

    localparam int unsigned FRAC = CWIDTH - 2;
    localparam int unsigned MW   = IWIDTH + 1;
    localparam int unsigned PW   = MW + CWIDTH;
    localparam int unsigned SW   = PW + 1;
    localparam int unsigned FW   = PW + 2;
    localparam int unsigned RSH  = FRAC + SHIFT;

    logic adv;

    logic [5:0] vld_q, vld_d;
    logic [5:0] aux_q, aux_d;
    logic [3:0] dit_q, dit_d;

    logic signed [IWIDTH-1:0] s0_lre_q, s0_lim_q, s0_rre_q, s0_rim_q;
    logic signed [IWIDTH-1:0] s0_lre_d, s0_lim_d, s0_rre_d, s0_rim_d;
    logic signed [CWIDTH-1:0] s0_cre_q, s0_cim_q, s0_cre_d, s0_cim_d;

    logic signed [MW-1:0]     s1_are_q, s1_aim_q, s1_mre_q, s1_mim_q;
    logic signed [MW-1:0]     s1_are_d, s1_aim_d, s1_mre_d, s1_mim_d;
    logic signed [CWIDTH-1:0] s1_cre_q, s1_cim_q, s1_cre_d, s1_cim_d;

    logic signed [PW-1:0]     s2_rr_q, s2_ii_q, s2_ri_q, s2_ir_q;
    logic signed [PW-1:0]     s2_rr_d, s2_ii_d, s2_ri_d, s2_ir_d;
    logic signed [MW-1:0]     s2_are_q, s2_aim_q, s2_are_d, s2_aim_d;

    logic signed [SW-1:0]     s3_pre_q, s3_pim_q, s3_pre_d, s3_pim_d;
    logic signed [MW-1:0]     s3_are_q, s3_aim_q, s3_are_d, s3_aim_d;

    logic signed [FW-1:0]     s4_lre_q, s4_lim_q, s4_rre_q, s4_rim_q;
    logic signed [FW-1:0]     s4_lre_d, s4_lim_d, s4_rre_d, s4_rim_d;
    logic signed [FW-1:0]     ash_re, ash_im, pex_re, pex_im;

    logic [OWIDTH-1:0]        s5_lre_q, s5_lim_q, s5_rre_q, s5_rim_q;
    logic [OWIDTH-1:0]        s5_lre_d, s5_lim_d, s5_rre_d, s5_rim_d;
    logic                     s5_ovf_q, s5_ovf_d;
    logic [OWIDTH:0]          rd_lre, rd_lim, rd_rre, rd_rim;

    logic [OWIDTH-1:0]        o_lre_q, o_lim_q, o_rre_q, o_rim_q;
    logic [OWIDTH-1:0]        o_lre_d, o_lim_d, o_rre_d, o_rim_d;
    logic                     o_valid_q, o_valid_d, o_aux_q, o_aux_d, o_ovf_q, o_ovf_d;

    // Convergent rounding by 2^RSH; returns {overflow, wrapped-or-saturated value}.
    function automatic logic [OWIDTH:0] rnd(input logic signed [FW-1:0] x);
        logic signed [FW-1:0] q;
        logic [RSH-1:0]       rem;
        logic [RSH-1:0]       half;
        logic                 up;
        logic                 ovf;
        logic [OWIDTH-1:0]    res;
        q    = x >>> RSH;
        rem  = x[RSH-1:0];
        half = RSH'(1) << (RSH - 1);
        up   = (rem > half) || ((rem == half) && q[0]);
        q    = q + FW'(up);
        ovf  = (q[FW-1:OWIDTH-1] != {(FW-OWIDTH+1){q[OWIDTH-1]}});
`ifdef BUTTERFLY_HS_SAT_EN
        if (ovf) begin
            res = q[FW-1] ? {1'b1, {(OWIDTH-1){1'b0}}} : {1'b0, {(OWIDTH-1){1'b1}}};
        end else begin
            res = q[OWIDTH-1:0];
        end
`else
        res = q[OWIDTH-1:0];
`endif
        return {ovf, res};
    endfunction

    // Whole pipeline advances together; held output blocks everything behind it.
    assign adv     = i_clk_enable & ~(o_valid_q & ~i_ready);
    assign o_ready = i_reset_n & adv;
    assign o_left  = {o_lre_q, o_lim_q};
    assign o_right = {o_rre_q, o_rim_q};
    assign o_aux   = o_aux_q;
    assign o_valid = o_valid_q;
    assign o_ovf   = o_ovf_q;

    // Operands aligned to product scale so DIT add/sub stays exact.
    assign ash_re = FW'(s3_are_q) <<< FRAC;
    assign ash_im = FW'(s3_aim_q) <<< FRAC;
    assign pex_re = FW'(s3_pre_q);
    assign pex_im = FW'(s3_pim_q);

    always_comb begin
        vld_d = vld_q;   aux_d = aux_q;   dit_d = dit_q;
        s0_lre_d = s0_lre_q; s0_lim_d = s0_lim_q; s0_rre_d = s0_rre_q; s0_rim_d = s0_rim_q;
        s0_cre_d = s0_cre_q; s0_cim_d = s0_cim_q;
        s1_are_d = s1_are_q; s1_aim_d = s1_aim_q; s1_mre_d = s1_mre_q; s1_mim_d = s1_mim_q;
        s1_cre_d = s1_cre_q; s1_cim_d = s1_cim_q;
        s2_rr_d = s2_rr_q; s2_ii_d = s2_ii_q; s2_ri_d = s2_ri_q; s2_ir_d = s2_ir_q;
        s2_are_d = s2_are_q; s2_aim_d = s2_aim_q;
        s3_pre_d = s3_pre_q; s3_pim_d = s3_pim_q; s3_are_d = s3_are_q; s3_aim_d = s3_aim_q;
        s4_lre_d = s4_lre_q; s4_lim_d = s4_lim_q; s4_rre_d = s4_rre_q; s4_rim_d = s4_rim_q;
        s5_lre_d = s5_lre_q; s5_lim_d = s5_lim_q; s5_rre_d = s5_rre_q; s5_rim_d = s5_rim_q;
        s5_ovf_d = s5_ovf_q;
        o_lre_d = o_lre_q; o_lim_d = o_lim_q; o_rre_d = o_rre_q; o_rim_d = o_rim_q;
        o_valid_d = o_valid_q; o_aux_d = o_aux_q; o_ovf_d = o_ovf_q;

        rd_lre = rnd(s4_lre_q);
        rd_lim = rnd(s4_lim_q);
        rd_rre = rnd(s4_rre_q);
        rd_rim = rnd(s4_rim_q);

        if (adv) begin
            vld_d = {vld_q[4:0], i_valid};
            aux_d = {aux_q[4:0], i_aux};
            dit_d = {dit_q[2:0], i_dit};

            s0_lre_d = $signed(i_left[2*IWIDTH-1:IWIDTH]);
            s0_lim_d = $signed(i_left[IWIDTH-1:0]);
            s0_rre_d = $signed(i_right[2*IWIDTH-1:IWIDTH]);
            s0_rim_d = $signed(i_right[IWIDTH-1:0]);
            s0_cre_d = $signed(i_coef[2*CWIDTH-1:CWIDTH]);
            s0_cim_d = $signed(i_coef[CWIDTH-1:0]);

            // a: DIF sum or DIT left operand; m: multiplicand (L-R for DIF, R for DIT)
            s1_are_d = dit_q[0] ? MW'(s0_lre_q) : MW'(s0_lre_q) + MW'(s0_rre_q);
            s1_aim_d = dit_q[0] ? MW'(s0_lim_q) : MW'(s0_lim_q) + MW'(s0_rim_q);
            s1_mre_d = dit_q[0] ? MW'(s0_rre_q) : MW'(s0_lre_q) - MW'(s0_rre_q);
            s1_mim_d = dit_q[0] ? MW'(s0_rim_q) : MW'(s0_lim_q) - MW'(s0_rim_q);
            s1_cre_d = s0_cre_q;
            s1_cim_d = s0_cim_q;

            s2_rr_d  = PW'(s1_mre_q) * PW'(s1_cre_q);
            s2_ii_d  = PW'(s1_mim_q) * PW'(s1_cim_q);
            s2_ri_d  = PW'(s1_mre_q) * PW'(s1_cim_q);
            s2_ir_d  = PW'(s1_mim_q) * PW'(s1_cre_q);
            s2_are_d = s1_are_q;
            s2_aim_d = s1_aim_q;

            s3_pre_d = SW'(s2_rr_q) - SW'(s2_ii_q);
            s3_pim_d = SW'(s2_ri_q) + SW'(s2_ir_q);
            s3_are_d = s2_are_q;
            s3_aim_d = s2_aim_q;

            s4_lre_d = dit_q[3] ? ash_re + pex_re : ash_re;
            s4_lim_d = dit_q[3] ? ash_im + pex_im : ash_im;
            s4_rre_d = dit_q[3] ? ash_re - pex_re : pex_re;
            s4_rim_d = dit_q[3] ? ash_im - pex_im : pex_im;

            s5_lre_d = rd_lre[OWIDTH-1:0];
            s5_lim_d = rd_lim[OWIDTH-1:0];
            s5_rre_d = rd_rre[OWIDTH-1:0];
            s5_rim_d = rd_rim[OWIDTH-1:0];
            s5_ovf_d = rd_lre[OWIDTH] | rd_lim[OWIDTH] | rd_rre[OWIDTH] | rd_rim[OWIDTH];

            o_lre_d   = s5_lre_q;
            o_lim_d   = s5_lim_q;
            o_rre_d   = s5_rre_q;
            o_rim_d   = s5_rim_q;
            o_valid_d = vld_q[5];
            o_aux_d   = aux_q[5];
        end

        // Set has priority over a simultaneous clear.
        if (i_clk_enable && i_ovf_clr) begin
            o_ovf_d = 1'b0;
        end
        if (adv && vld_q[5] && s5_ovf_q) begin
            o_ovf_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            vld_q <= '0; aux_q <= '0; dit_q <= '0;
            s0_lre_q <= '0; s0_lim_q <= '0; s0_rre_q <= '0; s0_rim_q <= '0;
            s0_cre_q <= '0; s0_cim_q <= '0;
            s1_are_q <= '0; s1_aim_q <= '0; s1_mre_q <= '0; s1_mim_q <= '0;
            s1_cre_q <= '0; s1_cim_q <= '0;
            s2_rr_q <= '0; s2_ii_q <= '0; s2_ri_q <= '0; s2_ir_q <= '0;
            s2_are_q <= '0; s2_aim_q <= '0;
            s3_pre_q <= '0; s3_pim_q <= '0; s3_are_q <= '0; s3_aim_q <= '0;
            s4_lre_q <= '0; s4_lim_q <= '0; s4_rre_q <= '0; s4_rim_q <= '0;
            s5_lre_q <= '0; s5_lim_q <= '0; s5_rre_q <= '0; s5_rim_q <= '0;
            s5_ovf_q <= 1'b0;
            o_lre_q <= '0; o_lim_q <= '0; o_rre_q <= '0; o_rim_q <= '0;
            o_valid_q <= 1'b0; o_aux_q <= 1'b0; o_ovf_q <= 1'b0;
        end else begin
            vld_q <= vld_d; aux_q <= aux_d; dit_q <= dit_d;
            s0_lre_q <= s0_lre_d; s0_lim_q <= s0_lim_d; s0_rre_q <= s0_rre_d; s0_rim_q <= s0_rim_d;
            s0_cre_q <= s0_cre_d; s0_cim_q <= s0_cim_d;
            s1_are_q <= s1_are_d; s1_aim_q <= s1_aim_d; s1_mre_q <= s1_mre_d; s1_mim_q <= s1_mim_d;
            s1_cre_q <= s1_cre_d; s1_cim_q <= s1_cim_d;
            s2_rr_q <= s2_rr_d; s2_ii_q <= s2_ii_d; s2_ri_q <= s2_ri_d; s2_ir_q <= s2_ir_d;
            s2_are_q <= s2_are_d; s2_aim_q <= s2_aim_d;
            s3_pre_q <= s3_pre_d; s3_pim_q <= s3_pim_d; s3_are_q <= s3_are_d; s3_aim_q <= s3_aim_d;
            s4_lre_q <= s4_lre_d; s4_lim_q <= s4_lim_d; s4_rre_q <= s4_rre_d; s4_rim_q <= s4_rim_d;
            s5_lre_q <= s5_lre_d; s5_lim_q <= s5_lim_d; s5_rre_q <= s5_rre_d; s5_rim_q <= s5_rim_d;
            s5_ovf_q <= s5_ovf_d;
            o_lre_q <= o_lre_d; o_lim_q <= o_lim_d; o_rre_q <= o_rre_d; o_rim_q <= o_rim_d;
            o_valid_q <= o_valid_d; o_aux_q <= o_aux_d; o_ovf_q <= o_ovf_d;
        end
    end

endmodule

// File: tb/tb_butterfly_hs.sv
// Scoreboard bench for butterfly_hs: default, SHIFT=1 and OWIDTH=16 instances with directed vectors.
`timescale 1ns/1ps
module tb_butterfly_hs;

    localparam longint ONE = 262144;
`ifdef BUTTERFLY_HS_SAT_EN
    localparam longint OVF_POS = 32767;
    localparam longint OVF_NEG = -32768;
`else
    localparam longint OVF_POS = -2;
    localparam longint OVF_NEG = 0;
`endif

    typedef struct {
        longint lr, li, rr, ri;
        bit     aux;
        bit     ovf;
        int     acc;
        bit     lat;
    } exp_t;

    exp_t q[$], qs[$], qo[$];
    int tests = 0, fails = 0;
    int cyc = 0;
    bit rand_rdy = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n, rst2_n, en, valid, dit, aux, rdy_in, ovf_clr;
    logic [31:0] left, right;
    logic [39:0] coef;
    logic        o_ready, o_valid, o_aux, o_ovf;
    logic [33:0] o_left, o_right;

    logic [31:0] b_left, b_right;
    logic [39:0] b_coef;
    logic        b_dit, b_aux, sh_valid, ow_valid, ow_clr;
    logic        sh_ready, sh_vout, sh_aux, sh_ovf, ow_ready, ow_vout, ow_aux, ow_ovf;
    logic [33:0] sh_left, sh_right;
    logic [31:0] ow_left, ow_right;

    butterfly_hs u_dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_clk_enable(en),
        .i_left(left), .i_right(right), .i_coef(coef), .i_dit(dit), .i_aux(aux),
        .i_valid(valid), .o_ready(o_ready), .o_left(o_left), .o_right(o_right),
        .o_aux(o_aux), .o_valid(o_valid), .i_ready(rdy_in), .i_ovf_clr(ovf_clr), .o_ovf(o_ovf)
    );

    butterfly_hs #(.SHIFT(1)) u_sh (
        .i_clk(clk), .i_reset_n(rst2_n), .i_clk_enable(1'b1),
        .i_left(b_left), .i_right(b_right), .i_coef(b_coef), .i_dit(b_dit), .i_aux(b_aux),
        .i_valid(sh_valid), .o_ready(sh_ready), .o_left(sh_left), .o_right(sh_right),
        .o_aux(sh_aux), .o_valid(sh_vout), .i_ready(1'b1), .i_ovf_clr(1'b0), .o_ovf(sh_ovf)
    );

    butterfly_hs #(.OWIDTH(16)) u_ow (
        .i_clk(clk), .i_reset_n(rst2_n), .i_clk_enable(1'b1),
        .i_left(b_left), .i_right(b_right), .i_coef(b_coef), .i_dit(b_dit), .i_aux(b_aux),
        .i_valid(ow_valid), .o_ready(ow_ready), .o_left(ow_left), .o_right(ow_right),
        .o_aux(ow_aux), .o_valid(ow_vout), .i_ready(1'b1), .i_ovf_clr(ow_clr), .o_ovf(ow_ovf)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input longint lr, li, rr, ri, input bit a, o, lat);
        exp_t e;
        e.lr = lr; e.li = li; e.rr = rr; e.ri = ri;
        e.aux = a; e.ovf = o; e.lat = lat; e.acc = 0;
        return e;
    endfunction

    // Present one beat to the main DUT; leaves it asserted after the accepting edge.
    task automatic send(input longint lr, li, rr, ri, cr, ci, input bit d, a,
                        input longint elr, eli, err, eri, input bit lat);
        exp_t e;
        int   n;
        @(negedge clk);
        left  = {16'(lr), 16'(li)};
        right = {16'(rr), 16'(ri)};
        coef  = {20'(cr), 20'(ci)};
        dit = d; aux = a; valid = 1'b1;
        #1;
        n = 0;
        while (!o_ready && n < 500) begin
            @(negedge clk); #1; n++;
        end
        if (!o_ready) begin
            tests++; fails++;
            $display("FAIL main_accept_timeout: o_ready stuck at 0 after %0d cycles", n);
        end else begin
            e = mk(elr, eli, err, eri, a, 1'b0, lat);
            e.acc = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // One DIF beat with C=1.0 into the SHIFT=1 or OWIDTH=16 instance.
    task automatic send2(input bit to_ow, input longint lr, li, rr, ri, input bit a,
                         input longint elr, eli, err, eri, input bit eovf);
        @(negedge clk);
        b_left  = {16'(lr), 16'(li)};
        b_right = {16'(rr), 16'(ri)};
        b_coef  = {20'(ONE), 20'(0)};
        b_dit = 1'b0; b_aux = a;
        if (to_ow) ow_valid = 1'b1; else sh_valid = 1'b1;
        #1;
        if (to_ow) begin
            chk("ow_ready", ow_ready, 1);
            qo.push_back(mk(elr, eli, err, eri, a, eovf, 1'b0));
        end else begin
            chk("sh_ready", sh_ready, 1);
            qs.push_back(mk(elr, eli, err, eri, a, eovf, 1'b0));
        end
        @(posedge clk); #1;
        ow_valid = 1'b0; sh_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || qs.size() != 0 || qo.size() != 0) && n < 400) begin
            @(negedge clk); n++;
        end
        chk("drain_main", longint'(q.size()), 0);
        chk("drain_shift", longint'(qs.size()), 0);
        chk("drain_owidth", longint'(qo.size()), 0);
    endtask

    // Main monitor: delivery compare, latency, and hold-during-stall checks.
    initial begin : mon_main
        exp_t        e;
        logic [33:0] hl, hr;
        logic        ha;
        bit          stall_prev;
        stall_prev = 0; hl = '0; hr = '0; ha = 1'b0;
        forever begin
            @(negedge clk); #2;
            if (!rst_n) begin
                stall_prev = 0;
            end else begin
                if (stall_prev) begin
                    chk("hold_valid", o_valid, 1);
                    chk("hold_left", o_left, hl);
                    chk("hold_right", o_right, hr);
                    chk("hold_aux", o_aux, ha);
                end
                stall_prev = 0;
                if (o_valid) begin
                    if (rdy_in && en) begin
                        if (q.size() == 0) begin
                            tests++; fails++;
                            $display("FAIL main_unexpected_beat: left=%h right=%h with empty scoreboard",
                                     o_left, o_right);
                        end else begin
                            e = q.pop_front();
                            chk("main_left_re", $signed(o_left[33:17]), e.lr);
                            chk("main_left_im", $signed(o_left[16:0]), e.li);
                            chk("main_right_re", $signed(o_right[33:17]), e.rr);
                            chk("main_right_im", $signed(o_right[16:0]), e.ri);
                            chk("main_aux", o_aux, e.aux);
                            if (e.lat) chk("main_latency", cyc - e.acc, 6);
                        end
                    end else begin
                        stall_prev = 1; hl = o_left; hr = o_right; ha = o_aux;
                    end
                end
            end
        end
    end

    initial begin : mon_sh
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (rst2_n && sh_vout) begin
                if (qs.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL sh_unexpected_beat: left=%h", sh_left);
                end else begin
                    e = qs.pop_front();
                    chk("sh_left_re", $signed(sh_left[33:17]), e.lr);
                    chk("sh_left_im", $signed(sh_left[16:0]), e.li);
                    chk("sh_right_re", $signed(sh_right[33:17]), e.rr);
                    chk("sh_right_im", $signed(sh_right[16:0]), e.ri);
                    chk("sh_aux", sh_aux, e.aux);
                    chk("sh_ovf", sh_ovf, 0);
                end
            end
        end
    end

    initial begin : mon_ow
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (rst2_n && ow_vout) begin
                if (qo.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL ow_unexpected_beat: left=%h", ow_left);
                end else begin
                    e = qo.pop_front();
                    chk("ow_left_re", $signed(ow_left[31:16]), e.lr);
                    chk("ow_left_im", $signed(ow_left[15:0]), e.li);
                    chk("ow_right_re", $signed(ow_right[31:16]), e.rr);
                    chk("ow_right_im", $signed(ow_right[15:0]), e.ri);
                    chk("ow_aux", ow_aux, e.aux);
                    chk("ow_ovf_at_output", ow_ovf, e.ovf);
                end
            end
        end
    end

    initial begin : rdy_gen
        forever begin
            @(negedge clk);
            if (rand_rdy) begin
                rdy_in = 1'($urandom_range(0, 1));
                en     = ($urandom_range(0, 7) != 0);
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst_n = 1'b0; rst2_n = 1'b0; en = 1'b0; valid = 1'b0; dit = 1'b0; aux = 1'b0;
        rdy_in = 1'b1; ovf_clr = 1'b0; left = '0; right = '0; coef = '0;
        b_left = '0; b_right = '0; b_coef = '0; b_dit = 1'b0; b_aux = 1'b0;
        sh_valid = 1'b0; ow_valid = 1'b0; ow_clr = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        chk("reset_o_valid", o_valid, 0);
        chk("reset_o_ready", o_ready, 0);
        chk("reset_o_ovf", o_ovf, 0);
        chk("reset_o_aux", o_aux, 0);
        chk("reset_o_left", o_left, 0);
        chk("reset_o_right", o_right, 0);
        @(negedge clk);
        rst_n = 1'b1; rst2_n = 1'b1; en = 1'b1;

        // DIF with C=1.0 (latency checked), then back-to-back alternating DIT(C=j)/DIF
        send(100, -50, 20, 30, ONE, 0, 1'b0, 1'b1, 120, -20, 80, -80, 1'b1);
        send(100, -50, 20, 30, 0, ONE, 1'b1, 1'b0, 70, -30, 130, -70, 1'b1);
        send(100, -50, 20, 30, ONE, 0, 1'b0, 1'b1, 120, -20, 80, -80, 1'b1);
        send(100, -50, 20, 30, 0, ONE, 1'b1, 1'b1, 70, -30, 130, -70, 1'b1);
        idle(10);

        // 20-beat stream with random output backpressure and clock-enable gaps
        rand_rdy = 1;
        for (int k = 1; k <= 20; k++) begin
            if (k % 2 == 1)
                send(10*k, -k, k, 2*k, 0, ONE, 1'b1, (k % 3 == 0), 8*k, 0, 12*k, -2*k, 1'b0);
            else
                send(10*k, -k, k, 2*k, ONE, 0, 1'b0, (k % 3 == 0), 11*k, k, 9*k, -3*k, 1'b0);
        end
        idle(0);
        drain();
        @(negedge clk);
        rand_rdy = 0; rdy_in = 1'b1; en = 1'b1;
        idle(2);

        // Reset with four beats in flight: all discarded, next beat flows normally
        send(1, 1, 1, 1, ONE, 0, 1'b0, 1'b1, 2, 2, 0, 0, 1'b0);
        send(2, 2, 1, 1, ONE, 0, 1'b0, 1'b1, 3, 3, 1, 1, 1'b0);
        send(3, 3, 1, 1, ONE, 0, 1'b0, 1'b1, 4, 4, 2, 2, 1'b0);
        send(4, 4, 1, 1, ONE, 0, 1'b0, 1'b1, 5, 5, 3, 3, 1'b0);
        @(negedge clk);
        valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midreset_o_valid", o_valid, 0);
        chk("midreset_o_ready", o_ready, 0);
        q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send(7, 8, 1, 1, ONE, 0, 1'b0, 1'b1, 8, 9, 6, 7, 1'b1);
        idle(12);

        // SHIFT=1 convergent rounding (ties to even), incl. negative ties
        send2(1'b0, 3, 7, 0, 0, 1'b1, 2, 4, 2, 4, 1'b0);
        send2(1'b0, 1, 0, 0, 0, 1'b0, 0, 0, 0, 0, 1'b0);
        send2(1'b0, 5, 0, 0, 0, 1'b1, 2, 0, 2, 0, 1'b0);
        send2(1'b0, -3, 0, 0, 0, 1'b0, -2, 0, -2, 0, 1'b0);
        send2(1'b0, -1, 0, 0, 0, 1'b1, 0, 0, 0, 0, 1'b0);

        // OWIDTH=16 overflow: wrap/saturate, sticky flag, clear, set-beats-clear
        send2(1'b1, 32767, 0, 32767, 0, 1'b1, OVF_POS, 0, 0, 0, 1'b1);
        repeat (12) @(negedge clk);
        #1;
        chk("ow_ovf_sticky", ow_ovf, 1);
        @(negedge clk); ow_clr = 1'b1;
        @(negedge clk); ow_clr = 1'b0;
        #1;
        chk("ow_ovf_cleared", ow_ovf, 0);
        send2(1'b1, 1000, 0, 0, 0, 1'b0, 1000, 0, 1000, 0, 1'b0);
        repeat (10) @(negedge clk);
        ow_clr = 1'b1;
        send2(1'b1, -32768, 0, -32768, 0, 1'b0, OVF_NEG, 0, 0, 0, 1'b1);
        repeat (10) @(negedge clk);
        #1;
        chk("ow_ovf_after_clear_held", ow_ovf, 0);
        @(negedge clk); ow_clr = 1'b0;

        drain();
        #1;
        chk("main_ovf_never_set", o_ovf, 0);
        chk("main_idle_valid", o_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/butterfly_hs.md
BUTTERFLY_HS -- requirements
Module: butterfly_hs

Interface
REQ-001 SHALL have parameter IWIDTH, default 16: signed width of each real/imag input component.
REQ-002 SHALL have parameter CWIDTH, default 20: signed width of each twiddle component; 1.0 = 2^(CWIDTH-2).
REQ-003 SHALL have parameter OWIDTH, default 17: signed width of each output component.
REQ-004 SHALL have parameter SHIFT, default 0: extra right-shift applied before output rounding.
REQ-005 SHALL have port i_clk, input, 1: single clock, all state on rising edge.
REQ-006 SHALL have port i_reset_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port i_clk_enable, input, 1: global advance qualifier; low freezes all state.
REQ-008 SHALL have ports i_left, i_right, input, 2*IWIDTH: operands {real, imag}.
REQ-009 SHALL have port i_coef, input, 2*CWIDTH: twiddle {real, imag}.
REQ-010 SHALL have port i_dit, input, 1: per-beat mode; 0 = DIF, 1 = DIT.
REQ-011 SHALL have port i_aux, input, 1: sideband bit carried with the beat.
REQ-012 SHALL have port i_valid, input, 1; o_ready, output, 1: input handshake.
REQ-013 SHALL have ports o_left, o_right, output, 2*OWIDTH: results {real, imag}.
REQ-014 SHALL have port o_aux, output, 1: i_aux of the beat currently on the outputs.
REQ-015 SHALL have port o_valid, output, 1; i_ready, input, 1: output handshake.
REQ-016 SHALL have port i_ovf_clr, input, 1; o_ovf, output, 1: sticky overflow flag and its clear.

Function
REQ-017 SHALL accept a beat when i_valid & o_ready & i_clk_enable; deliver it when o_valid & i_ready & i_clk_enable.
REQ-018 SHALL implement a 6-stage pipeline; a beat accepted at edge N is on outputs with o_valid=1 after edge N+6 absent stalls.
REQ-019 SHALL drive o_ready = i_clk_enable & ~(o_valid & ~i_ready); whole pipeline stalls together, no beat lost or duplicated.
REQ-020 SHALL hold o_left, o_right, o_aux, o_valid stable while o_valid & ~i_ready.
REQ-021 SHALL carry pipeline bubbles (invalid stages) so throughput is one beat per enabled, unstalled cycle.
REQ-022 DIF (i_dit=0): L' = L + R; R' = (L - R) * C, complex.
REQ-023 DIT (i_dit=1): P = R * C; L' = L + P; R' = L - P.
REQ-024 Products SHALL be full precision then scaled by 2^-(CWIDTH-2); sums SHALL be exact with one bit growth.
REQ-025 Each output component SHALL be convergent-rounded (round half to even) value / 2^SHIFT.
REQ-026 A rounded component not representable in OWIDTH bits SHALL be an overflow; default behaviour wraps (low OWIDTH bits).
REQ-027 o_ovf SHALL set on the cycle an overflowing beat is first presented on the outputs and remain set until i_ovf_clr or reset; simultaneous set and clear SHALL leave o_ovf=1.
REQ-028 i_dit and i_aux SHALL be sampled with the beat; mode changes between consecutive beats SHALL take effect per beat with no bubble.

Reset
REQ-029 SHALL on i_reset_n=0 immediately clear o_valid, o_ovf, o_aux, o_left, o_right and all stage-valid bits, regardless of i_clk_enable.
REQ-030 SHALL discard all in-flight beats on reset mid-operation; first output after release is the first beat accepted after release.
REQ-031 SHALL drive o_ready=0 while i_reset_n=0.

Configuration
REQ-032 With macro BUTTERFLY_HS_SAT_EN defined, overflowing components SHALL saturate to +2^(OWIDTH-1)-1 or -2^(OWIDTH-1); without it they wrap per REQ-026; o_ovf behaves identically in both.

Verification (IWIDTH=16, CWIDTH=20, OWIDTH=17, SHIFT=0 unless stated; C=1.0 is (262144,0), j is (0,262144))
REQ-033 DIF, L=(100,-50), R=(20,30), C=1.0 -> o_left=(120,-20), o_right=(80,-80), o_valid exactly 6 cycles after acceptance.
REQ-034 DIT, same L,R, C=j -> o_left=(70,-30), o_right=(130,-70); alternating DIF/DIT back-to-back beats each correct.
REQ-035 SHIFT=1, DIF, R=0, C=1.0: L=(3,0) -> o_left=(2,0); L=(1,0) -> o_left=(0,0); L=(5,0) -> o_left=(2,0).
REQ-036 OWIDTH=16, DIF, L=R=(32767,0) -> o_left real -2 without macro, 32767 with BUTTERFLY_HS_SAT_EN; o_ovf=1 until i_ovf_clr pulse.
REQ-037 Stream 20 beats with i_ready toggled randomly -> all 20 delivered in order, aux intact, outputs held during stall.
REQ-038 Assert i_reset_n=0 with 4 beats in flight -> o_valid=0 immediately; none of the 4 appear after release.
